// File: rtl/aliens_bus_cycle_ctrl.sv
// Bus-cycle sequencer behind the 053327-D20 decode PAL: per-region wait states,
// registered chip selects, one-cycle RD/WR strobes and the I/O bank latch feeding RMRD.
//
// state  | meaning
// IDLE   | no access in flight; an armed CPU request starts one
// WAIT   | region wait states, RDY low, latched chip select asserted
// STROBE | single-cycle RD_n/WR_n pulse, RDY released
// HOLD   | chip select kept low for HOLD_CYC cycles after the strobe
module aliens_bus_cycle_ctrl #(
    parameter int WAIT_IO   = 2,
    parameter int WAIT_CRAM = 1,
    parameter int WAIT_VRAM = 1,
    parameter int WAIT_OBJ  = 1,
    parameter int WAIT_DEF  = 0,
    parameter int HOLD_CYC  = 1,
    parameter int RMRD_BIT  = 5
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CPU_REQ,
    input  logic       CPU_RW,
    input  logic [7:0] CPU_D,
    input  logic       IOCS,
    input  logic       CRAMCS,
    input  logic       VRAMCS,
    input  logic       OBJCS,
    output logic       RDY,
    output logic       RD_n,
    output logic       WR_n,
    output logic       IOCS_Q,
    output logic       CRAMCS_Q,
    output logic       VRAMCS_Q,
    output logic       OBJCS_Q,
    output logic [7:0] BANK_Q,
    output logic       RMRD,
    output logic       CS_ERR
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_STROBE,
        ST_HOLD
    } state_t;

    typedef enum logic [2:0] {
        RGN_NONE,
        RGN_IO,
        RGN_CRAM,
        RGN_VRAM,
        RGN_OBJ
    } region_t;

    localparam logic [3:0] W_IO   = 4'(WAIT_IO);
    localparam logic [3:0] W_CRAM = 4'(WAIT_CRAM);
    localparam logic [3:0] W_VRAM = 4'(WAIT_VRAM);
    localparam logic [3:0] W_OBJ  = 4'(WAIT_OBJ);
    localparam logic [3:0] W_DEF  = 4'(WAIT_DEF);
    localparam logic [3:0] HOLD   = 4'(HOLD_CYC);

    state_t     state_q, state_d;
    region_t    region_q, region_d;
    region_t    req_region;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] req_wait;
    logic       rw_q, rw_d;
    logic       armed_q, armed_d;
    logic       start;
    logic       sel_active;
    logic [2:0] cs_low_cnt;
    logic       multi_cs;

    logic rdy_d, rd_n_d, wr_n_d, cs_err_d;
    logic iocs_d, cramcs_d, vramcs_d, objcs_d;

    // Region decode with IO > OBJ > VRAM > CRAM priority when the PAL asserts several
    always_comb begin
        req_region = RGN_NONE;
        req_wait   = W_DEF;
        if (!IOCS) begin
            req_region = RGN_IO;
            req_wait   = W_IO;
        end else if (!OBJCS) begin
            req_region = RGN_OBJ;
            req_wait   = W_OBJ;
        end else if (!VRAMCS) begin
            req_region = RGN_VRAM;
            req_wait   = W_VRAM;
        end else if (!CRAMCS) begin
            req_region = RGN_CRAM;
            req_wait   = W_CRAM;
        end
    end

    assign cs_low_cnt = {2'b00, ~IOCS} + {2'b00, ~CRAMCS} + {2'b00, ~VRAMCS} + {2'b00, ~OBJCS};
    assign multi_cs   = (cs_low_cnt > 3'd1);
    assign start      = (state_q == ST_IDLE) && armed_q && CPU_REQ;

    // Output values are decoded from the current state and registered, so every
    // pin waveform trails the state register by exactly one cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        region_d   = region_q;
        rw_d       = rw_q;
        armed_d    = armed_q;
        sel_active = 1'b0;
        rdy_d      = 1'b1;
        rd_n_d     = 1'b1;
        wr_n_d     = 1'b1;
        cs_err_d   = 1'b0;

        if (!CPU_REQ) begin
            armed_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    armed_d  = 1'b0;
                    region_d = req_region;
                    rw_d     = CPU_RW;
                    cnt_d    = req_wait;
                    rdy_d    = 1'b0;
                    cs_err_d = multi_cs;
                    state_d  = (req_wait != 4'd0) ? ST_WAIT : ST_STROBE;
                end
            end
            ST_WAIT: begin
                rdy_d      = 1'b0;
                sel_active = 1'b1;
                cnt_d      = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = ST_STROBE;
                end
            end
            ST_STROBE: begin
                sel_active = 1'b1;
                rd_n_d     = ~rw_q;
                wr_n_d     = rw_q;
                cnt_d      = HOLD;
                state_d    = (HOLD != 4'd0) ? ST_HOLD : ST_IDLE;
            end
            ST_HOLD: begin
                sel_active = 1'b1;
                cnt_d      = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        iocs_d   = ~(sel_active && (region_q == RGN_IO));
        cramcs_d = ~(sel_active && (region_q == RGN_CRAM));
        vramcs_d = ~(sel_active && (region_q == RGN_VRAM));
        objcs_d  = ~(sel_active && (region_q == RGN_OBJ));
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            region_q <= RGN_NONE;
            rw_q     <= 1'b1;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            region_q <= region_d;
            rw_q     <= rw_d;
            armed_q  <= armed_d;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            RDY      <= 1'b1;
            RD_n     <= 1'b1;
            WR_n     <= 1'b1;
            IOCS_Q   <= 1'b1;
            CRAMCS_Q <= 1'b1;
            VRAMCS_Q <= 1'b1;
            OBJCS_Q  <= 1'b1;
            CS_ERR   <= 1'b0;
        end else begin
            RDY      <= rdy_d;
            RD_n     <= rd_n_d;
            WR_n     <= wr_n_d;
            IOCS_Q   <= iocs_d;
            CRAMCS_Q <= cramcs_d;
            VRAMCS_Q <= vramcs_d;
            OBJCS_Q  <= objcs_d;
            CS_ERR   <= cs_err_d;
        end
    end

    // Bank data is taken at the end of the visible write-strobe cycle
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            BANK_Q <= 8'h00;
        end else if (!WR_n && (region_q == RGN_IO)) begin
            BANK_Q <= CPU_D;
        end
    end

    assign RMRD = BANK_Q[RMRD_BIT];

endmodule

// File: tb/tb_aliens_bus_cycle_ctrl.sv
// Self-checking bench for aliens_bus_cycle_ctrl: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a timeline model.
`timescale 1ns/1ps
module tb_aliens_bus_cycle_ctrl;

    localparam int HOLD = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       CPU_REQ = 1'b0;
    logic       CPU_RW = 1'b1;
    logic [7:0] CPU_D = 8'h00;
    logic       IOCS = 1'b1, CRAMCS = 1'b1, VRAMCS = 1'b1, OBJCS = 1'b1;
    logic       RDY, RD_n, WR_n, IOCS_Q, CRAMCS_Q, VRAMCS_Q, OBJCS_Q, RMRD, CS_ERR;
    logic [7:0] BANK_Q;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    aliens_bus_cycle_ctrl dut (
        .CLK(clk), .RST(rst), .CPU_REQ(CPU_REQ), .CPU_RW(CPU_RW), .CPU_D(CPU_D),
        .IOCS(IOCS), .CRAMCS(CRAMCS), .VRAMCS(VRAMCS), .OBJCS(OBJCS),
        .RDY(RDY), .RD_n(RD_n), .WR_n(WR_n), .IOCS_Q(IOCS_Q), .CRAMCS_Q(CRAMCS_Q),
        .VRAMCS_Q(VRAMCS_Q), .OBJCS_Q(OBJCS_Q), .BANK_Q(BANK_Q), .RMRD(RMRD), .CS_ERR(CS_ERR)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: an access started at edge e0 with W wait states shows, d cycles later,
    // RDY low for d<=W, the strobe at d=W+1 and the region select low for 1<=d<=W+HOLD+1.
    int         n_edge = 0;
    int         m_e0, m_w, m_region, m_lows, m_d;
    bit         m_active, m_armed, m_rw, m_idle, m_start;
    logic [7:0] m_bank;
    logic       e_rdy, e_rd_n, e_wr_n, e_io, e_cram, e_vram, e_obj, e_err;

    function automatic int wait_of(input int region);
        case (region)
            1: return 2;
            2: return 1;
            3: return 1;
            4: return 1;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 0; m_armed = 0; m_bank = 8'h00; m_e0 = 0; m_w = 0; m_region = 0; m_rw = 1;
            e_rdy = 1; e_rd_n = 1; e_wr_n = 1; e_io = 1; e_cram = 1; e_vram = 1; e_obj = 1; e_err = 0;
        end else begin
            n_edge++;
            if (m_active && n_edge == m_e0 + m_w + 2 && !m_rw && m_region == 1) m_bank = CPU_D;
            m_idle  = !m_active || (n_edge >= m_e0 + m_w + HOLD + 2);
            m_start = m_idle && m_armed && (CPU_REQ == 1'b1);
            m_lows  = (IOCS ? 0 : 1) + (CRAMCS ? 0 : 1) + (VRAMCS ? 0 : 1) + (OBJCS ? 0 : 1);
            e_err   = m_start && (m_lows > 1);
            if (m_start) begin
                m_active = 1;
                m_e0     = n_edge;
                m_rw     = CPU_RW;
                if (!IOCS) m_region = 1;
                else if (!OBJCS) m_region = 4;
                else if (!VRAMCS) m_region = 3;
                else if (!CRAMCS) m_region = 2;
                else m_region = 0;
                m_w = wait_of(m_region);
                m_armed = 0;
            end else if (!CPU_REQ) begin
                m_armed = 1;
            end
            e_rdy = 1; e_rd_n = 1; e_wr_n = 1; e_io = 1; e_cram = 1; e_vram = 1; e_obj = 1;
            m_d = n_edge - m_e0;
            if (m_active && m_d <= m_w + HOLD + 1) begin
                e_rdy  = (m_d > m_w);
                e_rd_n = !(m_rw && m_d == m_w + 1);
                e_wr_n = !(!m_rw && m_d == m_w + 1);
                if (m_d >= 1) begin
                    e_io   = (m_region != 1);
                    e_cram = (m_region != 2);
                    e_vram = (m_region != 3);
                    e_obj  = (m_region != 4);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("RDY", {7'b0, RDY}, {7'b0, e_rdy});
            check("RD_n", {7'b0, RD_n}, {7'b0, e_rd_n});
            check("WR_n", {7'b0, WR_n}, {7'b0, e_wr_n});
            check("IOCS_Q", {7'b0, IOCS_Q}, {7'b0, e_io});
            check("CRAMCS_Q", {7'b0, CRAMCS_Q}, {7'b0, e_cram});
            check("VRAMCS_Q", {7'b0, VRAMCS_Q}, {7'b0, e_vram});
            check("OBJCS_Q", {7'b0, OBJCS_Q}, {7'b0, e_obj});
            check("CS_ERR", {7'b0, CS_ERR}, {7'b0, e_err});
            check("BANK_Q", BANK_Q, m_bank);
            check("RMRD", {7'b0, RMRD}, {7'b0, m_bank[5]});
        end
    end

    int t_rdy, t_rd, t_wr, t_io, t_cram, t_vram, t_obj, t_err;

    task automatic clear_tally();
        t_rdy = 0; t_rd = 0; t_wr = 0; t_io = 0; t_cram = 0; t_vram = 0; t_obj = 0; t_err = 0;
    endtask

    task automatic tally();
        if (!RDY) t_rdy++;
        if (!RD_n) t_rd++;
        if (!WR_n) t_wr++;
        if (!IOCS_Q) t_io++;
        if (!CRAMCS_Q) t_cram++;
        if (!VRAMCS_Q) t_vram++;
        if (!OBJCS_Q) t_obj++;
        if (CS_ERR) t_err++;
    endtask

    task automatic tally_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tally();
        end
    endtask

    task automatic set_cs(input logic [3:0] cs_n);
        {IOCS, CRAMCS, VRAMCS, OBJCS} = cs_n;
    endtask

    // One access: arm with a low REQ cycle, request for one cycle, then observe 12 cycles
    task automatic do_access(input logic rw, input logic [7:0] d, input logic [3:0] cs_n);
        @(negedge clk); CPU_REQ = 0; set_cs(4'hF);
        @(negedge clk); CPU_REQ = 1; CPU_RW = rw; CPU_D = d; set_cs(cs_n);
        clear_tally();
        @(negedge clk); CPU_REQ = 0; set_cs(4'hF); tally();
        tally_cycles(11);
    endtask

    initial begin
        #2 rst = 1;
        repeat (2) @(negedge clk);
        chk_en = 1;
        check("rst RDY", {7'b0, RDY}, 8'd1);
        check("rst BANK_Q", BANK_Q, 8'h00);
        check("rst IOCS_Q", {7'b0, IOCS_Q}, 8'd1);
        rst = 0;

        do_access(1'b1, 8'h00, 4'b0111);
        check("io rd RDY low", 8'(t_rdy), 8'd3);
        check("io rd RD_n low", 8'(t_rd), 8'd1);
        check("io rd IOCS_Q low", 8'(t_io), 8'd4);
        check("io rd WR_n low", 8'(t_wr), 8'd0);

        do_access(1'b0, 8'h20, 4'b0111);
        check("io wr BANK_Q", BANK_Q, 8'h20);
        check("io wr RMRD", {7'b0, RMRD}, 8'd1);
        check("io wr WR_n low", 8'(t_wr), 8'd1);
        do_access(1'b0, 8'h00, 4'b0111);
        check("io wr0 RMRD", {7'b0, RMRD}, 8'd0);

        do_access(1'b1, 8'h00, 4'b1010);
        check("multi OBJCS_Q low", 8'(t_obj), 8'd3);
        check("multi CRAMCS_Q low", 8'(t_cram), 8'd0);
        check("multi CS_ERR pulses", 8'(t_err), 8'd1);

        @(negedge clk); CPU_REQ = 0; set_cs(4'hF);
        @(negedge clk); CPU_REQ = 1; CPU_RW = 1;
        clear_tally();
        tally_cycles(20);
        check("held REQ strobes", 8'(t_rd), 8'd1);
        CPU_REQ = 0;
        @(negedge clk); CPU_REQ = 1;
        clear_tally();
        tally_cycles(10);
        check("rearm strobes", 8'(t_rd), 8'd1);
        CPU_REQ = 0;

        do_access(1'b0, 8'hA5, 4'b0111);
        check("pre-rst BANK_Q", BANK_Q, 8'hA5);
        @(negedge clk); CPU_REQ = 0; set_cs(4'hF);
        @(negedge clk); CPU_REQ = 1; CPU_RW = 0; CPU_D = 8'h3C; set_cs(4'b1101);
        @(posedge clk); #1 CPU_REQ = 0; set_cs(4'hF);
        @(posedge clk); #2;
        check("wait VRAMCS_Q", {7'b0, VRAMCS_Q}, 8'd0);
        check("wait RDY", {7'b0, RDY}, 8'd0);
        rst = 1;
        #1;
        check("rst-mid RDY", {7'b0, RDY}, 8'd1);
        check("rst-mid WR_n", {7'b0, WR_n}, 8'd1);
        check("rst-mid VRAMCS_Q", {7'b0, VRAMCS_Q}, 8'd1);
        check("rst-mid BANK_Q", BANK_Q, 8'h00);
        @(negedge clk); rst = 0;
        clear_tally();
        tally_cycles(10);
        check("post-rst WR_n low", 8'(t_wr), 8'd0);

        do_access(1'b1, 8'h00, 4'b1111);
        check("unmapped RDY low", 8'(t_rdy), 8'd1);
        check("unmapped RD_n low", 8'(t_rd), 8'd1);
        check("unmapped Q low", 8'(t_io + t_cram + t_vram + t_obj), 8'd0);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst = 0;
            if (CPU_REQ) CPU_REQ = ($urandom_range(0, 3) != 0);
            else CPU_REQ = ($urandom_range(0, 1) != 0);
            CPU_RW = $urandom_range(0, 1);
            CPU_D  = 8'($urandom_range(0, 255));
            IOCS   = ($urandom_range(0, 99) >= 35);
            CRAMCS = ($urandom_range(0, 99) >= 35);
            VRAMCS = ($urandom_range(0, 99) >= 35);
            OBJCS  = ($urandom_range(0, 99) >= 35);
            if ($urandom_range(0, 399) == 0) begin
                @(posedge clk); #2 rst = 1;
            end
        end
        @(negedge clk); rst = 0;
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
